mod_inv64_module: RTL

MOD_INV64_MODULE -- requirements
Module: mod_inv64_module

---
 rtl/mod_inv64_module.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mod_inv64_module.sv
// rtl/mod_inv64_module.sv - sequential modular inverse P = A^-1 mod N (binary extended gcd)
module mod_inv64_module #(
  parameter int A_WIDTH = 64,
  parameter int N_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] A,
  input  logic [N_WIDTH-1:0] N,
  output logic [N_WIDTH-1:0] P,
  output logic               done,
  output logic               err
);

  localparam int IW = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, REDUCE, LOOP, FIN} state_t;

  state_t             state, state_nx;
  logic [A_WIDTH-1:0] a_q, a_nx;
  logic [N_WIDTH-1:0] n_q, n_nx;
  logic [N_WIDTH:0]   r_q, r_nx;
  logic [IW-1:0]      idx_q, idx_nx;
  logic [N_WIDTH-1:0] u_q, u_nx, v_q, v_nx;
  logic [N_WIDTH-1:0] x1_q, x1_nx, x2_q, x2_nx;
  logic               fail_q, fail_nx;
  logic [N_WIDTH-1:0] p_q, p_nx;
  logic               err_q, err_nx;
  logic               done_q, done_nx;

  logic [N_WIDTH:0]   r_shift;
  logic [N_WIDTH:0]   r_red;

  // Divide x by two modulo an odd n: add n first when x is odd so the sum is even.
  function automatic logic [N_WIDTH-1:0] half_mod(input logic [N_WIDTH-1:0] x,
                                                  input logic [N_WIDTH-1:0] n);
    logic [N_WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, n}) : {1'b0, x};
    return s[N_WIDTH:1];
  endfunction

  // (a - b) mod n for a, b in [0, n-1]; wrap-around of the fixed width cancels out.
  function automatic logic [N_WIDTH-1:0] sub_mod(input logic [N_WIDTH-1:0] a,
                                                 input logic [N_WIDTH-1:0] b,
                                                 input logic [N_WIDTH-1:0] n);
    return (a >= b) ? (a - b) : (a - b + n);
  endfunction

  assign P    = p_q;
  assign err  = err_q;
  assign done = done_q;

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      idx_q  <= '0;
      u_q    <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      fail_q <= 1'b0;
      p_q    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      a_q    <= a_nx;
      n_q    <= n_nx;
      r_q    <= r_nx;
      idx_q  <= idx_nx;
      u_q    <= u_nx;
      v_q    <= v_nx;
      x1_q   <= x1_nx;
      x2_q   <= x2_nx;
      fail_q <= fail_nx;
      p_q    <= p_nx;
      err_q  <= err_nx;
      done_q <= done_nx;
    end
  end

  // Next-state and datapath: reduce A mod N bit-serially, then run the binary inverse loop.
  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    n_nx     = n_q;
    r_nx     = r_q;
    idx_nx   = idx_q;
    u_nx     = u_q;
    v_nx     = v_q;
    x1_nx    = x1_q;
    x2_nx    = x2_q;
    fail_nx  = fail_q;
    p_nx     = p_q;
    err_nx   = err_q;
    done_nx  = 1'b0;

    // r < N, so 2r + bit < 2N fits in N_WIDTH+1 bits and one conditional subtract suffices.
    r_shift  = {r_q[N_WIDTH-1:0], a_q[idx_q]};
    r_red    = (r_shift >= {1'b0, n_q}) ? (r_shift - {1'b0, n_q}) : r_shift;

    case (state)
      IDLE: begin
        // A start coinciding with the completion pulse belongs to the finished request.
        if (start && !done_q) begin
          a_nx   = A;
          n_nx   = N;
          r_nx   = '0;
          idx_nx = IW'(A_WIDTH - 1);
          u_nx   = '0;
          v_nx   = '0;
          x1_nx  = '0;
          x2_nx  = '0;
          if (!N[0] || (N < N_WIDTH'(3))) begin
            fail_nx  = 1'b1;
            state_nx = FIN;
          end else begin
            fail_nx  = 1'b0;
            state_nx = REDUCE;
          end
        end
      end

      REDUCE: begin
        r_nx = r_red;
        if (idx_q == '0) begin
          if (r_red == '0) begin
            fail_nx  = 1'b1;
            state_nx = FIN;
          end else begin
            u_nx     = r_red[N_WIDTH-1:0];
            v_nx     = n_q;
            x1_nx    = N_WIDTH'(1);
            x2_nx    = '0;
            state_nx = LOOP;
          end
        end else begin
          idx_nx = idx_q - 1'b1;
        end
      end

      LOOP: begin
        // Invariants: x1 * r == u and x2 * r == v (mod N).
        if ((u_q == N_WIDTH'(1)) || (v_q == N_WIDTH'(1))) begin
          state_nx = FIN;
        end else if (u_q == '0) begin
          fail_nx  = 1'b1;
          state_nx = FIN;
        end else if (!u_q[0]) begin
          u_nx  = u_q >> 1;
          x1_nx = half_mod(x1_q, n_q);
        end else if (!v_q[0]) begin
          v_nx  = v_q >> 1;
          x2_nx = half_mod(x2_q, n_q);
        end else if (u_q >= v_q) begin
          u_nx  = u_q - v_q;
          x1_nx = sub_mod(x1_q, x2_q, n_q);
        end else begin
          v_nx  = v_q - u_q;
          x2_nx = sub_mod(x2_q, x1_q, n_q);
        end
      end

      FIN: begin
        p_nx     = fail_q ? '0 : ((u_q == N_WIDTH'(1)) ? x1_q : x2_q);
        err_nx   = fail_q;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
